// File: rtl/memory_sequence_controller_pkg.sv
// Shared definitions for the memory game: state encodings, button/LED widths and
// the button-code to LED decode used by the sequencer and the LED driver.
package memory_sequence_controller_pkg;

  localparam int unsigned BtnW    = 2;
  localparam int unsigned NumLeds = 4;
  localparam int unsigned LevelW  = 6;

  typedef logic [BtnW-1:0]    btn_code_t;
  typedef logic [NumLeds-1:0] led_t;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGen     = 3'd1;
  localparam logic [2:0] StShowOn  = 3'd2;
  localparam logic [2:0] StShowOff = 3'd3;
  localparam logic [2:0] StInput   = 3'd4;
  localparam logic [2:0] StWin     = 3'd5;
  localparam logic [2:0] StLose    = 3'd6;

  function automatic led_t code_to_led(input btn_code_t code);
    led_t led;
    led       = '0;
    led[code] = 1'b1;
    return led;
  endfunction

endpackage

// File: rtl/memory_sequence_controller_if.sv
// Game-side bus of the memory sequencer: LFSR tap, button encoder input and
// LED/score outputs. The sequencer connects through the slave modport.
interface memory_sequence_controller_if;
  import memory_sequence_controller_pkg::*;

  logic              start;
  logic [3:0]        rng_q;
  logic              rng_enable;
  logic              btn_valid;
  btn_code_t         btn_code;
  led_t              led_onehot;
  logic [LevelW-1:0] level;
  logic              busy;
  logic              win;
  logic              lose;

  modport master (
    output start, rng_q, btn_valid, btn_code,
    input  rng_enable, led_onehot, level, busy, win, lose
  );

  modport slave (
    input  start, rng_q, btn_valid, btn_code,
    output rng_enable, led_onehot, level, busy, win, lose
  );

endinterface

// File: rtl/memory_sequence_controller_ram.sv
// Sequence storage: 2**AddrW entries, synchronous write, asynchronous read.
module memory_sequence_ram #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Entries = 1 << AddrW;

  logic [DataW-1:0] mem_q [Entries];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_sequence_controller.sv
// Memory game sequencer: grows a random button sequence one step per level, plays it
// back on the LEDs, then checks the player's presses against it.
module memory_sequence_controller
  import memory_sequence_controller_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000
) (
  input  logic                         clk,
  input  logic                         rst,
  memory_sequence_controller_if.slave  bus
);

  localparam int unsigned MaxCycles = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
  localparam int unsigned IdxW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TimerW-1:0] ShowLast = TimerW'(SHOW_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);
  localparam logic [LevelW-1:0] MaxLevel = LevelW'(MAX_LEN);
  localparam logic [LevelW-1:0] LevelOne = LevelW'(1);

  logic [2:0]        state_q, state_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic [LevelW-1:0] level_m1;
  logic              idx_last;
  logic              seq_we;
  btn_code_t         seq_rd;
  logic [1:0]        unused_rng;

  assign level_m1   = level_q - LevelOne;
  assign idx_last   = (LevelW'(idx_q) == level_m1);
  assign seq_we     = (state_q == StGen);
  assign unused_rng = bus.rng_q[3:2];

  // GEN writes the new step at level-1; playback and input checking read at idx.
  memory_sequence_ram #(
    .AddrW (IdxW),
    .DataW (BtnW)
  ) u_seq_ram (
    .clk_i   (clk),
    .we_i    (seq_we),
    .waddr_i (level_m1[IdxW-1:0]),
    .wdata_i (bus.rng_q[BtnW-1:0]),
    .raddr_i (idx_q),
    .rdata_o (seq_rd)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (bus.start) begin
          level_d = LevelOne;
          state_d = StGen;
        end
      end
      StGen: begin
        idx_d   = '0;
        timer_d = '0;
        state_d = StShowOn;
      end
      StShowOn: begin
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = StShowOff;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StShowOff: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (idx_last) begin
            idx_d   = '0;
            state_d = StInput;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StShowOn;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StInput: begin
        // start is deliberately not looked at here, even alongside btn_valid.
        if (bus.btn_valid) begin
          if (bus.btn_code != seq_rd) begin
            state_d = StLose;
          end else if (!idx_last) begin
            idx_d = idx_q + IdxW'(1);
          end else if (level_q == MaxLevel) begin
            state_d = StWin;
          end else begin
            level_d = level_q + LevelOne;
            state_d = StGen;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      level_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    bus.led_onehot = (state_q == StShowOn) ? code_to_led(seq_rd) : '0;
    bus.level      = level_q;
    bus.busy       = (state_q == StGen) || (state_q == StShowOn) || (state_q == StShowOff);
    bus.win        = (state_q == StWin);
    bus.lose       = (state_q == StLose);
    // LFSR free-runs while waiting on the player, frozen during playback.
    bus.rng_enable = ~rst & ((state_q == StIdle) || (state_q == StInput) ||
                             (state_q == StWin)  || (state_q == StLose));
  end

endmodule

// File: tb/tb_memory_sequence_controller.sv
// Directed bench for the memory game sequencer with MAX_LEN=3, SHOW=2, GAP=1.
module tb_memory_sequence_controller;

  localparam int unsigned MaxLen = 3;
  localparam int unsigned Show   = 2;
  localparam int unsigned Gap    = 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  memory_sequence_controller_if bus ();

  memory_sequence_controller #(
    .MAX_LEN     (MaxLen),
    .SHOW_CYCLES (Show),
    .GAP_CYCLES  (Gap)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want run complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] code);
    bus.btn_valid = 1'b1;
    bus.btn_code  = code;
    tick();
    bus.btn_valid = 1'b0;
  endtask

  // Called with the DUT in GEN; codes[2s+1:2s] is the button shown at step s.
  task automatic run_playback(input string name, input logic [5:0] codes, input int n);
    tick();
    for (int s = 0; s < n; s++) begin
      logic [1:0] c;
      logic [3:0] exp_led;
      c       = codes[2*s +: 2];
      exp_led = 4'b0001 << c;
      for (int k = 0; k < Show; k++) begin
        checks++;
        if (bus.led_onehot !== exp_led || bus.busy !== 1'b1 || bus.rng_enable !== 1'b0) begin
          errors++;
          $display("FAIL %s show step %0d cyc %0d: led=%b busy=%b rng_en=%b, want led=%b busy=1 rng_en=0",
                   name, s, k, bus.led_onehot, bus.busy, bus.rng_enable, exp_led);
        end
        tick();
      end
      for (int k = 0; k < Gap; k++) begin
        checks++;
        if (bus.led_onehot !== 4'b0000 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s gap step %0d: led=%b busy=%b, want led=0000 busy=1",
                   name, s, bus.led_onehot, bus.busy);
        end
        tick();
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.led_onehot !== 4'b0000 || bus.rng_enable !== 1'b1) begin
      errors++;
      $display("FAIL %s enter input: busy=%b led=%b rng_en=%b, want busy=0 led=0000 rng_en=1",
               name, bus.busy, bus.led_onehot, bus.rng_enable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.level !== 6'd0 || bus.led_onehot !== 4'b0000 || bus.win !== 1'b0 ||
          bus.lose !== 1'b0 || bus.busy !== 1'b0 || bus.rng_enable !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d: level=%0d led=%b win=%b lose=%b busy=%b rng_en=%b, want all 0",
                 i, bus.level, bus.led_onehot, bus.win, bus.lose, bus.busy, bus.rng_enable);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rng_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rng_en=%b, want 1", bus.rng_enable);
    end
  endtask

  task automatic test_first_level();
    bus.rng_q = 4'b0110;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.level !== 6'd1 || bus.busy !== 1'b1 || bus.rng_enable !== 1'b0) begin
      errors++;
      $display("FAIL start_gen: level=%0d busy=%b rng_en=%b, want level=1 busy=1 rng_en=0",
               bus.level, bus.busy, bus.rng_enable);
    end
    run_playback("level1", 6'b00_00_10, 1);
    checks++;
    if (bus.level !== 6'd1) begin
      errors++;
      $display("FAIL level1_input: level=%0d, want 1", bus.level);
    end
  endtask

  task automatic test_append();
    bus.rng_q = 4'b1001;
    press(2'd2);
    checks++;
    if (bus.level !== 6'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL append: level=%0d busy=%b, want level=2 busy=1", bus.level, bus.busy);
    end
    run_playback("level2", 6'b00_01_10, 2);
  endtask

  task automatic test_win();
    // start alongside a correct press in INPUT must only advance idx.
    bus.start = 1'b1;
    press(2'd2);
    bus.start = 1'b0;
    checks++;
    if (bus.level !== 6'd2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_input: level=%0d busy=%b, want level=2 busy=0", bus.level, bus.busy);
    end
    bus.rng_q = 4'b0011;
    press(2'd1);
    checks++;
    if (bus.level !== 6'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL advance3: level=%0d busy=%b, want level=3 busy=1", bus.level, bus.busy);
    end
    run_playback("level3", 6'b11_01_10, 3);
    press(2'd2);
    press(2'd1);
    press(2'd3);
    checks++;
    if (bus.win !== 1'b1 || bus.lose !== 1'b0 || bus.level !== 6'd3 || bus.busy !== 1'b0 ||
        bus.rng_enable !== 1'b1) begin
      errors++;
      $display("FAIL win: win=%b lose=%b level=%0d busy=%b rng_en=%b, want 1 0 3 0 1",
               bus.win, bus.lose, bus.level, bus.busy, bus.rng_enable);
    end
    press(2'd0);
    checks++;
    if (bus.win !== 1'b1 || bus.level !== 6'd3) begin
      errors++;
      $display("FAIL win_sticky: win=%b level=%0d, want win=1 level=3", bus.win, bus.level);
    end
    bus.rng_q = 4'b0110;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.level !== 6'd1 || bus.busy !== 1'b1 || bus.win !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_win: level=%0d busy=%b win=%b, want 1 1 0",
               bus.level, bus.busy, bus.win);
    end
    run_playback("replay1", 6'b00_00_10, 1);
  endtask

  task automatic test_lose();
    bus.rng_q = 4'b1001;
    press(2'd2);
    run_playback("lose_l2", 6'b00_01_10, 2);
    press(2'd2);
    press(2'd0);
    checks++;
    if (bus.lose !== 1'b1 || bus.win !== 1'b0 || bus.led_onehot !== 4'b0000 ||
        bus.level !== 6'd2 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL lose: lose=%b win=%b led=%b level=%0d busy=%b, want 1 0 0000 2 0",
               bus.lose, bus.win, bus.led_onehot, bus.level, bus.busy);
    end
    press(2'd1);
    checks++;
    if (bus.lose !== 1'b1 || bus.level !== 6'd2) begin
      errors++;
      $display("FAIL lose_sticky: lose=%b level=%0d, want lose=1 level=2", bus.lose, bus.level);
    end
    bus.rng_q = 4'b0110;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.led_onehot !== 4'b0100 || bus.level !== 6'd1) begin
      errors++;
      $display("FAIL restart_from_lose: led=%b level=%0d, want led=0100 level=1",
               bus.led_onehot, bus.level);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.led_onehot !== 4'b0100 || bus.level !== 6'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_show: led=%b level=%0d busy=%b, want led=0100 level=1 busy=1",
               bus.led_onehot, bus.level, bus.busy);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.level !== 6'd1) begin
      errors++;
      $display("FAIL after_show_start: busy=%b level=%0d, want busy=0 level=1",
               bus.busy, bus.level);
    end
  endtask

  task automatic test_mid_show_reset();
    bus.rng_q = 4'b1001;
    press(2'd2);
    tick();
    checks++;
    if (bus.led_onehot !== 4'b0100 || bus.level !== 6'd2) begin
      errors++;
      $display("FAIL pre_reset_show: led=%b level=%0d, want led=0100 level=2",
               bus.led_onehot, bus.level);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.led_onehot !== 4'b0000 || bus.level !== 6'd0 || bus.busy !== 1'b0 ||
        bus.win !== 1'b0 || bus.lose !== 1'b0 || bus.rng_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_show_reset: led=%b level=%0d busy=%b win=%b lose=%b rng_en=%b, want all 0",
               bus.led_onehot, bus.level, bus.busy, bus.win, bus.lose, bus.rng_enable);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rng_enable !== 1'b1 || bus.level !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_reset: rng_en=%b level=%0d, want rng_en=1 level=0",
               bus.rng_enable, bus.level);
    end
    bus.rng_q = 4'b0011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.level !== 6'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_reset: level=%0d busy=%b, want level=1 busy=1",
               bus.level, bus.busy);
    end
    run_playback("post_reset", 6'b00_00_11, 1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.rng_q     = 4'b0000;
    bus.btn_valid = 1'b0;
    bus.btn_code  = 2'd0;
    test_reset();
    test_first_level();
    test_append();
    test_win();
    test_lose();
    test_mid_show_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
